key_event_gen: RTL
==================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd25000: Clock cycles per timing tick; 0 is treated as 1.
REQ-002 SHALL have parameter REP_DLY, default 16'd500: ticks from press to the first repeat; 0 disables repeat.
REQ-003 SHALL have parameter REP_INT, default 16'd100: ticks between subsequent repeats.
REQ-004 SHALL have port Clock  in  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port btn  in  4  debounced button levels (1 = pressed), one bit per button, driven by the debouncer stage.
REQ-007 SHALL have port ev_valid  out  1  FIFO head holds an event.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts the head event this cycle.
REQ-009 SHALL have port ev_data  out  4  {type[1:0], idx[1:0]}; type 00 press, 01 release, 10 repeat; 11 is never emitted.
REQ-010 SHALL have port ovf  out  1  sticky event-loss flag.
REQ-011 SHALL have port clr_ovf  in  1  clears ovf.

Function
REQ-012 SHALL run a 16-bit down-counting prescaler reloaded with TICK_DIV-1 and pulse tick for one cycle each time it reaches 0, then reload.
REQ-013 SHALL keep, per button, an FSM with states UP, WAIT and RPT, plus a 16-bit tick timer.
REQ-014 UP with btn=1 SHALL go to WAIT, load timer with REP_DLY, and emit press.
REQ-015 WAIT or RPT with btn=0 SHALL go to UP and emit release; release takes priority over a same-cycle repeat.
REQ-016 WAIT with tick, btn=1 and REP_DLY≠0 SHALL decrement the timer when it is nonzero; when the timer is 0 it SHALL emit repeat, go to RPT and load REP_INT.
REQ-017 RPT with tick, btn=1 SHALL decrement the timer when it is nonzero; when the timer is 0 it SHALL emit repeat and reload REP_INT.
REQ-018 The first repeat SHALL follow (REP_DLY+1) ticks after press; subsequent repeats SHALL occur every (REP_INT+1) ticks.
REQ-019 Each emitted event SHALL be written into a per-button single-entry pending slot at the same edge as the FSM transition.
REQ-020 FSM transitions SHALL never stall on a full slot or a full FIFO.
REQ-021 If a slot is still full (not drained this cycle) when a new event is emitted for that button, the new event SHALL be dropped and ovf set to 1.
REQ-022 Each cycle the FIFO is not full, or is popped this cycle, an arbiter SHALL move the lowest-index full pending slot into the FIFO and free that slot.
REQ-023 A slot drained and refilled in the same cycle SHALL hold the new event with no overflow.
REQ-024 The event FIFO SHALL be 4 entries, in order, with 2-bit pointers that wrap and a 3-bit count.
REQ-025 The FIFO SHALL pop when ev_valid&&ev_ready.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged, including when full.
REQ-027 ev_data SHALL equal the head entry when ev_valid=1, and 4'b0000 otherwise.
REQ-028 Latency: a btn change present before edge k SHALL give a pending event at edge k, a FIFO write at edge k+1, and ev_valid=1 after edge k+1 if the FIFO was empty.
REQ-029 ovf SHALL be cleared by clr_ovf; a same-cycle set SHALL win over clear.

Reset
REQ-030 Reset=1 at an edge SHALL set all FSMs to UP, all timers to 0, all pending slots empty, FIFO pointers and count to 0, and the prescaler to TICK_DIV-1.
REQ-031 During reset, ev_valid, ev_data and ovf SHALL read 0.
REQ-032 Reset SHALL override all other inputs, including mid-operation.
REQ-033 A button held through reset SHALL emit press on the first non-reset cycle.

Verification (TICK_DIV=2, REP_DLY=3, REP_INT=2)
REQ-034 btn=0001 held, ev_ready=1 -> ev_data=0000 valid 2 cycles after btn rises; then 1000 after 4 ticks (8 cycles), then every 3 ticks (6 cycles).
REQ-035 btn 0001->0000 while in WAIT -> single event 0100 with 2-cycle latency; no repeat follows.
REQ-036 btn 0000->0101 in one cycle -> events 0000 then 0010 on consecutive cycles; ovf=0.
REQ-037 ev_ready=0; press btn0–3 -> FIFO full (4 entries), ev_valid=1; then toggle btn1 twice -> ovf=1. Raise ev_ready -> presses idx0..3 drained in order, followed by btn1's pending release.
REQ-038 Reset pulsed with 3 events queued and btn=0010 held -> ev_valid=0 during reset; first event after reset is 0001; ovf=0.
REQ-039 clr_ovf=1 with no overflow that cycle -> ovf=0 next cycle; clr_ovf coinciding with an overflow -> ovf stays 1.

Source files
------------

// File: rtl/key_event_gen.sv
// Four-button key event generator: press/release/auto-repeat per button,
// per-button pending slots, lowest-index arbitration into a 4-deep event FIFO.
//
// state | meaning
// UP    | button released, waiting for press
// WAIT  | pressed, counting down the initial repeat delay
// RPT   | auto-repeating at the repeat interval
module key_event_gen #(
  parameter logic [15:0] TICK_DIV = 16'd25000,
  parameter logic [15:0] REP_DLY  = 16'd500,
  parameter logic [15:0] REP_INT  = 16'd100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] btn,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_data,
  output logic       ovf,
  input  logic       clr_ovf
);

  typedef enum logic [1:0] {UP, WAIT, RPT} state_t;

  localparam logic [1:0] T_PRESS = 2'b00;
  localparam logic [1:0] T_REL   = 2'b01;
  localparam logic [1:0] T_RPT   = 2'b10;
  localparam logic [15:0] RELOAD = (TICK_DIV == 16'd0) ? 16'd0 : TICK_DIV - 16'd1;

  logic [15:0] presc;
  logic        tick;

  state_t      state_q [4];
  state_t      state_d [4];
  logic [15:0] timer_q [4];
  logic [15:0] timer_d [4];
  logic [3:0]  emit;
  logic [1:0]  emit_type [4];

  logic [3:0]  slot_v;
  logic [1:0]  slot_t [4];
  logic [3:0]  drain;
  logic [3:0]  lost;

  logic [3:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        fifo_full, pop, push;
  logic [3:0]  push_data;
  logic        ovf_q;

  assign tick = (presc == 16'd0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      emit[i]      = 1'b0;
      emit_type[i] = T_PRESS;
      case (state_q[i])
        UP: begin
          if (btn[i]) begin
            state_d[i]   = WAIT;
            timer_d[i]   = REP_DLY;
            emit[i]      = 1'b1;
            emit_type[i] = T_PRESS;
          end
        end
        WAIT, RPT: begin
          if (!btn[i]) begin
            state_d[i]   = UP;
            timer_d[i]   = 16'd0;
            emit[i]      = 1'b1;
            emit_type[i] = T_REL;
          end else if (tick && (state_q[i] == RPT || REP_DLY != 16'd0)) begin
            if (timer_q[i] != 16'd0) begin
              timer_d[i] = timer_q[i] - 16'd1;
            end else begin
              state_d[i]   = RPT;
              timer_d[i]   = REP_INT;
              emit[i]      = 1'b1;
              emit_type[i] = T_RPT;
            end
          end
        end
        default: state_d[i] = UP;
      endcase
    end
  end

  assign fifo_full = (count == 3'd4);
  assign ev_valid  = !Reset && (count != 3'd0);
  assign pop       = ev_valid && ev_ready;
  assign ev_data   = ev_valid ? mem[rd_ptr] : 4'b0000;
  assign ovf       = ovf_q && !Reset;

  // Descending scan so the lowest full slot wins the grant.
  always_comb begin
    drain     = 4'b0000;
    push      = 1'b0;
    push_data = 4'b0000;
    if (!fifo_full || pop) begin
      for (int i = 3; i >= 0; i--) begin
        if (slot_v[i]) begin
          drain     = 4'b0000;
          drain[i]  = 1'b1;
          push      = 1'b1;
          push_data = {slot_t[i], 2'(i)};
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lost[i] = emit[i] && slot_v[i] && !drain[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc  <= RELOAD;
      slot_v <= 4'b0000;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= UP;
        timer_q[i] <= 16'd0;
        slot_t[i]  <= 2'b00;
        mem[i]     <= 4'b0000;
      end
    end else begin
      presc <= tick ? RELOAD : presc - 16'd1;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        if (emit[i] && !lost[i]) begin
          slot_v[i] <= 1'b1;
          slot_t[i] <= emit_type[i];
        end else if (drain[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
      if (|lost) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
